// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM states,
// default program-counter geometry and the sequential increment.
package fetch_pkg;

    localparam int PC_W     = 6;
    localparam int RESET_PC = 0;
    localparam int PC_INC   = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection for the RUN state. Purely combinational; the caller
// decides whether the result is actually loaded (it is ignored in BOOT/HALT).
module pc_next_mux #(
    parameter int PC_W = fetch_pkg::PC_W
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic            halt_req_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    output logic [PC_W-1:0] pc_next_o,
    output logic            redirect_o,
    output logic            misalign_o
);
    import fetch_pkg::*;

    logic [PC_W-1:0] raw_target;

    // Priority: halt > stall > branch > jump > sequential. Branch wins over a
    // simultaneous jump; redirect targets are word-aligned and any dropped
    // low bits are reported as a misalignment.
    always_comb begin
        pc_next_o  = pc_i;
        redirect_o = 1'b0;
        misalign_o = 1'b0;
        raw_target = branch_target_i;
        if (halt_req_i || stall_i) begin
            pc_next_o = pc_i;
        end else if (branch_taken_i) begin
            raw_target = branch_target_i;
            redirect_o = 1'b1;
        end else if (jump_i) begin
            raw_target = jump_target_i;
            redirect_o = 1'b1;
        end else begin
            pc_next_o = pc_i + PC_W'(PC_INC);
        end
        if (redirect_o) begin
            pc_next_o  = {raw_target[PC_W-1:2], 2'b00};
            misalign_o = |raw_target[1:0];
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, the BOOT/RUN/HALT control FSM, the
// IF/ID write/flush controls and a saturating count of delivered fetches.
module fetch_sequencer #(
    parameter int PC_W     = fetch_pkg::PC_W,
    parameter int RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            halt_req,
    output logic [PC_W-1:0] PC,
    output logic            IF_Flush,
    output logic            IF_ID_Write,
    output logic            misalign,
    output logic            halted,
    output logic [7:0]      fetch_count
);
    import fetch_pkg::*;

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [7:0]      count_q;
    logic            misalign_q;
    logic            halted_q;
    logic            redirect;
    logic            misalign_d;

    pc_next_mux #(
        .PC_W (PC_W)
    ) u_pc_next_mux (
        .pc_i            (pc_q),
        .halt_req_i      (halt_req),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .pc_next_o       (pc_d),
        .redirect_o      (redirect),
        .misalign_o      (misalign_d)
    );

    // IF/ID controls: flush is combinational so a redirect squashes the
    // wrong-path fetch in the same cycle; a stall freezes IF/ID outright.
    always_comb begin
        IF_Flush    = 1'b1;
        IF_ID_Write = 1'b1;
        if (!reset && state_q == RUN) begin
            if (halt_req) begin
                IF_Flush    = 1'b1;
                IF_ID_Write = 1'b1;
            end else if (stall) begin
                IF_Flush    = 1'b0;
                IF_ID_Write = 1'b0;
            end else if (branch_taken || jump) begin
                IF_Flush    = 1'b1;
                IF_ID_Write = 1'b1;
            end else begin
                IF_Flush    = 1'b0;
                IF_ID_Write = 1'b1;
            end
        end
    end

    // Control FSM with PC register, registered status flags and fetch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC_V;
            count_q    <= 8'd0;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            if (IF_ID_Write && !IF_Flush && count_q != 8'hFF) begin
                count_q <= count_q + 8'd1;
            end
            case (state_q)
                BOOT: begin
                    // One cycle to cover synchronous instruction-memory latency.
                    state_q    <= RUN;
                    misalign_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
                RUN: begin
                    if (halt_req) begin
                        state_q    <= HALT;
                        misalign_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end else begin
                        pc_q       <= pc_d;
                        misalign_q <= redirect && misalign_d;
                        halted_q   <= 1'b0;
                    end
                end
                HALT: begin
                    misalign_q <= 1'b0;
                    halted_q   <= 1'b1;
                end
                default: begin
                    state_q    <= BOOT;
                    pc_q       <= RESET_PC_V;
                    misalign_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign PC          = pc_q;
    assign misalign    = misalign_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_fetch_sequencer;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       branch_taken;
    logic [5:0] branch_target;
    logic       jump;
    logic [5:0] jump_target;
    logic       halt_req;
    logic [5:0] PC;
    logic       IF_Flush;
    logic       IF_ID_Write;
    logic       misalign;
    logic       halted;
    logic [7:0] fetch_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: mode 0=booting, 1=running, 2=halted.
    int m_mode;
    int m_pc;
    int m_count;
    int m_mis;
    int m_halted;

    fetch_sequencer #(
        .PC_W     (6),
        .RESET_PC (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .PC            (PC),
        .IF_Flush      (IF_Flush),
        .IF_ID_Write   (IF_ID_Write),
        .misalign      (misalign),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model by the architectural rules at the rising edge.
    task automatic step(input logic r, input logic st, input logic bt, input logic [5:0] btg,
                        input logic j, input logic [5:0] jtg, input logic h);
        int e_flush;
        int e_write;
        @(negedge clk);
        reset = r; stall = st; branch_taken = bt; branch_target = btg;
        jump = j; jump_target = jtg; halt_req = h;
        #1;
        if (r || m_mode != 1) begin
            e_flush = 1; e_write = 1;
        end else if (h) begin
            e_flush = 1; e_write = 1;
        end else if (st) begin
            e_flush = 0; e_write = 0;
        end else if (bt || j) begin
            e_flush = 1; e_write = 1;
        end else begin
            e_flush = 0; e_write = 1;
        end
        $display("cyc=%0d rst=%0b stall=%0b br=%0b/%0d jmp=%0b/%0d halt=%0b | PC=%0d flush=%0b wr=%0b mis=%0b hlt=%0b cnt=%0d",
                 cyc, r, st, bt, btg, j, jtg, h, PC, IF_Flush, IF_ID_Write, misalign, halted, fetch_count);
        check_eq("pc", 32'(PC), 32'(m_pc));
        check_eq("if_flush", 32'(IF_Flush), 32'(e_flush));
        check_eq("if_id_write", 32'(IF_ID_Write), 32'(e_write));
        check_eq("misalign", 32'(misalign), 32'(m_mis));
        check_eq("halted", 32'(halted), 32'(m_halted));
        check_eq("fetch_count", 32'(fetch_count), 32'(m_count));
        @(posedge clk);
        cyc++;
        if (r) begin
            m_mode = 0; m_pc = 0; m_count = 0; m_mis = 0; m_halted = 0;
        end else begin
            if (e_write == 1 && e_flush == 0 && m_count < 255) m_count++;
            m_mis = 0;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (h) begin
                    m_mode = 2; m_halted = 1;
                end else if (st) begin
                    m_pc = m_pc;
                end else if (bt) begin
                    m_pc  = (int'(btg) / 4) * 4;
                    m_mis = (int'(btg) % 4 != 0) ? 1 : 0;
                end else if (j) begin
                    m_pc  = (int'(jtg) / 4) * 4;
                    m_mis = (int'(jtg) % 4 != 0) ? 1 : 0;
                end else begin
                    m_pc = (m_pc + 4) % 64;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; halt_req = 1'b0;
        // Unchecked power-on reset so the DUT leaves X before the model is trusted.
        repeat (2) @(posedge clk);
        m_mode = 0; m_pc = 0; m_count = 0; m_mis = 0; m_halted = 0;

        // Reset release: one BOOT cycle, then 0,4,8,...
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        idle(5);

        // Wrap from 56 through 60 to 0.
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd56, 1'b0);
        idle(4);
        #1 check_eq("wrap_pc", 32'(PC), 32'd8);

        // Stall with pending branch, then branch after stall drops.
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd12, 1'b0);
        step(1'b0, 1'b1, 1'b1, 6'd40, 1'b0, 6'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 6'd40, 1'b0, 6'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 6'd40, 1'b0, 6'd0, 1'b0);
        #1 check_eq("branch_after_stall_pc", 32'(PC), 32'd40);

        // Branch and jump together: misaligned branch target wins.
        step(1'b0, 1'b0, 1'b1, 6'd22, 1'b1, 6'd8, 1'b0);
        #1 check_eq("both_redirect_pc", 32'(PC), 32'd20);
        check_eq("both_redirect_mis", 32'(misalign), 32'd1);
        idle(2);

        // Halt at PC=16 with redirects presented afterwards.
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd16, 1'b0);
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 6'd44, 1'b0, 6'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 6'd32, 1'b0);
        step(1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 6'd5, 1'b1);
        #1 check_eq("halt_pc", 32'(PC), 32'd16);
        check_eq("halt_flag", 32'(halted), 32'd1);

        // Reset in HALT, then reset during a redirect cycle.
        step(1'b1, 1'b0, 1'b1, 6'd48, 1'b0, 6'd0, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 1'b1, 6'd33, 1'b1, 6'd20, 1'b0);
        #1 check_eq("reset_redirect_pc", 32'(PC), 32'd0);
        check_eq("reset_redirect_cnt", 32'(fetch_count), 32'd0);

        // Long free run to hit counter saturation.
        idle(300);
        #1 check_eq("count_saturate", 32'(fetch_count), 32'd255);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 15, 6'($urandom_range(0, 63)),
                 $urandom_range(0, 99) < 15, 6'($urandom_range(0, 63)),
                 $urandom_range(0, 99) < 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
